// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for the 5-stage pipeline.
// It resolves memory-miss, branch, load-use and jump hazards, owns the
// data-memory request/ready handshake and halts the pipeline on a memory timeout.
// Optional build macro HAZARD_PERF_EN adds the stall/flush performance counters.
// Without that macro, stall_cycles and flush_count are constant zero.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 8
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [4:0]  ID_rs,
  input  logic [4:0]  ID_rt,
  input  logic        ID_useRs,
  input  logic        ID_useRt,
  input  logic        EXE_MemRead,
  input  logic [4:0]  EXE_writeSrc,
  input  logic        MEM_MemRead,
  input  logic        MEM_MemWrite,
  input  logic        branch_taken,
  input  logic        jump,
  input  logic        dmem_ready,
  output logic        PC_write,
  output logic        IF_ID_write,
  output logic        IF_ID_flush,
  output logic        ID_EXE_bubble,
  output logic        ID_EXE_write,
  output logic        EXE_MEM_write,
  output logic        MEM_WB_bubble,
  output logic        dmem_req,
  output logic        halted,
  output logic [31:0] stall_cycles,
  output logic [15:0] flush_count
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;

  logic w_mem_acc;
  logic w_load_use;
  logic w_freeze;

  assign w_mem_acc  = MEM_MemRead | MEM_MemWrite;
  assign w_load_use = EXE_MemRead && (EXE_writeSrc != 5'd0) &&
                      ((ID_useRs && (ID_rs == EXE_writeSrc)) ||
                       (ID_useRt && (ID_rt == EXE_writeSrc)));
  // A new miss freezes in RUN; once waiting, only dmem_ready releases the freeze.
  assign w_freeze   = (r_state == MEM_WAIT) ? !dmem_ready : (w_mem_acc && !dmem_ready);
  assign halted     = (r_state == HALT);

  // Mealy control outputs: reset forcing first, then HALT, freeze, and hazard priority.
  always_comb begin
    PC_write      = 1'b1;
    IF_ID_write   = 1'b1;
    IF_ID_flush   = 1'b0;
    ID_EXE_bubble = 1'b0;
    ID_EXE_write  = 1'b1;
    EXE_MEM_write = 1'b1;
    MEM_WB_bubble = 1'b0;
    dmem_req      = 1'b0;
    if (Reset) begin
      if (r_state == HALT) begin
        PC_write      = 1'b0;
        IF_ID_write   = 1'b0;
        ID_EXE_write  = 1'b0;
        EXE_MEM_write = 1'b0;
        MEM_WB_bubble = 1'b1;
      end else begin
        dmem_req = w_mem_acc;
        if (w_freeze) begin
          // Frozen stages hold any branch/jump/load-use and re-present it after release.
          PC_write      = 1'b0;
          IF_ID_write   = 1'b0;
          ID_EXE_write  = 1'b0;
          EXE_MEM_write = 1'b0;
          MEM_WB_bubble = 1'b1;
        end else if (branch_taken) begin
          IF_ID_flush   = 1'b1;
          ID_EXE_bubble = 1'b1;
        end else if (w_load_use) begin
          // Jump stays in held ID and is flushed on the following cycle.
          PC_write      = 1'b0;
          IF_ID_write   = 1'b0;
          ID_EXE_bubble = 1'b1;
        end else if (jump) begin
          IF_ID_flush = 1'b1;
        end
      end
    end
  end

  // State and wait counter: RUN -> MEM_WAIT on miss, MEM_WAIT -> RUN or HALT.
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      r_state <= RUN;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        RUN: begin
          if (w_freeze) begin
            r_state <= MEM_WAIT;
            r_cnt   <= CNT_W'(1);
          end
        end
        MEM_WAIT: begin
          if (dmem_ready) begin
            r_state <= RUN;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_W'(MEM_TIMEOUT - 1)) begin
            r_state <= HALT;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        HALT: begin
          r_state <= HALT;
        end
        default: begin
          r_state <= RUN;
          r_cnt   <= '0;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] r_stall_cycles;
  logic [15:0] r_flush_count;

  // Performance counters: saturating stall count, wrapping flush count.
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      if (!PC_write && (r_state != HALT) && (r_stall_cycles != '1))
        r_stall_cycles <= r_stall_cycles + 32'd1;
      if (IF_ID_flush)
        r_flush_count <= r_flush_count + 16'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_count  = r_flush_count;
`else
  assign stall_cycles = 32'd0;
  assign flush_count  = 16'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed vector table,
// hand-written multi-cycle sequences and a randomized run against a reference model.
module tb_pipe_hazard_ctrl;

  localparam int MT = 4;
  // Output vector order: {PC_write, IF_ID_write, IF_ID_flush, ID_EXE_bubble,
  //                       ID_EXE_write, EXE_MEM_write, MEM_WB_bubble, dmem_req, halted}
  localparam logic [8:0] DEF   = 9'b110011000;
  localparam logic [8:0] DEFRQ = 9'b110011010;
  localparam logic [8:0] LUS   = 9'b000111000;
  localparam logic [8:0] FRZ   = 9'b000000110;
  localparam logic [8:0] HLT   = 9'b000000101;

  logic        CLK = 1'b0;
  logic        Reset;
  logic [4:0]  ID_rs, ID_rt, EXE_writeSrc;
  logic        ID_useRs, ID_useRt, EXE_MemRead, MEM_MemRead, MEM_MemWrite;
  logic        branch_taken, jump, dmem_ready;
  logic        PC_write, IF_ID_write, IF_ID_flush, ID_EXE_bubble, ID_EXE_write;
  logic        EXE_MEM_write, MEM_WB_bubble, dmem_req, halted;
  logic [31:0] stall_cycles;
  logic [15:0] flush_count;

  int checks = 0;
  int failures = 0;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(8)) dut (
    .CLK(CLK), .Reset(Reset), .ID_rs(ID_rs), .ID_rt(ID_rt),
    .ID_useRs(ID_useRs), .ID_useRt(ID_useRt), .EXE_MemRead(EXE_MemRead),
    .EXE_writeSrc(EXE_writeSrc), .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite),
    .branch_taken(branch_taken), .jump(jump), .dmem_ready(dmem_ready),
    .PC_write(PC_write), .IF_ID_write(IF_ID_write), .IF_ID_flush(IF_ID_flush),
    .ID_EXE_bubble(ID_EXE_bubble), .ID_EXE_write(ID_EXE_write),
    .EXE_MEM_write(EXE_MEM_write), .MEM_WB_bubble(MEM_WB_bubble),
    .dmem_req(dmem_req), .halted(halted), .stall_cycles(stall_cycles),
    .flush_count(flush_count)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string      nm;
    logic       rst_n;
    logic [4:0] rs, rt, exrd;
    logic       urs, urt, exmr, mmr, mmw, br, jmp, rdy;
    logic [8:0] exp;
  } vec_t;

  // Reference model: halted flag, length of the current unanswered access, counters.
  bit          m_halt;
  int          m_waited;
  logic [31:0] m_stall;
  logic [15:0] m_flush;

  function automatic vec_t mk(string nm, logic rst_n, logic [4:0] rs, logic urs,
                              logic [4:0] rt, logic urt, logic exmr, logic [4:0] exrd,
                              logic mmr, logic mmw, logic br, logic jmp, logic rdy,
                              logic [8:0] exp);
    vec_t v;
    v.nm = nm; v.rst_n = rst_n; v.rs = rs; v.urs = urs; v.rt = rt; v.urt = urt;
    v.exmr = exmr; v.exrd = exrd; v.mmr = mmr; v.mmw = mmw; v.br = br;
    v.jmp = jmp; v.rdy = rdy; v.exp = exp;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    Reset = v.rst_n; ID_rs = v.rs; ID_useRs = v.urs; ID_rt = v.rt; ID_useRt = v.urt;
    EXE_MemRead = v.exmr; EXE_writeSrc = v.exrd; MEM_MemRead = v.mmr;
    MEM_MemWrite = v.mmw; branch_taken = v.br; jump = v.jmp; dmem_ready = v.rdy;
  endtask

  task automatic idle_inputs(input logic rst_n);
    apply(mk("", rst_n, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
  endtask

  // Expected outputs derived directly from the hazard rules.
  function automatic logic [8:0] model_out();
    logic req, lu, frozen, pcw, ifw, fl, bub;
    if (!Reset) return {8'b11001100, logic'(m_halt)};
    if (m_halt) return HLT;
    req    = MEM_MemRead | MEM_MemWrite;
    frozen = (m_waited > 0) ? !dmem_ready : (req && !dmem_ready);
    if (frozen) return {6'b000000, 1'b1, req, 1'b0};
    lu  = EXE_MemRead && (EXE_writeSrc != 0) &&
          ((ID_useRs && ID_rs == EXE_writeSrc) || (ID_useRt && ID_rt == EXE_writeSrc));
    pcw = 1; ifw = 1; fl = 0; bub = 0;
    if (branch_taken) begin fl = 1; bub = 1; end
    else if (lu) begin pcw = 0; ifw = 0; bub = 1; end
    else if (jump) fl = 1;
    return {pcw, ifw, fl, bub, 1'b1, 1'b1, 1'b0, req, 1'b0};
  endfunction

  function automatic void model_clock();
    logic [8:0] o;
    if (!Reset) begin
      m_halt = 0; m_waited = 0; m_stall = 0; m_flush = 0;
    end else if (!m_halt) begin
      o = model_out();
      if (!o[8] && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
      if (o[6]) m_flush = m_flush + 1;
      if (o[2]) begin
        m_waited = m_waited + 1;
        if (m_waited == MT) begin m_halt = 1; m_waited = 0; end
      end else begin
        m_waited = 0;
      end
    end
  endfunction

  task automatic check(input string nm, input logic [47:0] got, input logic [47:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", nm, got, exp);
    end
  endtask

  // One clock: inputs already set; compare near the negedge, then advance model at posedge.
  task automatic step(input logic [8:0] exp, input string nm);
    logic [31:0] es;
    logic [15:0] ef;
    #4;
    check(nm, 48'({PC_write, IF_ID_write, IF_ID_flush, ID_EXE_bubble, ID_EXE_write,
                   EXE_MEM_write, MEM_WB_bubble, dmem_req, halted}), 48'(exp));
`ifdef HAZARD_PERF_EN
    es = m_stall; ef = m_flush;
`else
    es = 0; ef = 0;
`endif
    check({nm, "_ctr"}, {stall_cycles, flush_count}, {es, ef});
    @(posedge CLK);
    model_clock();
    #1;
  endtask

  task automatic do_reset();
    idle_inputs(0);
    step({8'b11001100, logic'(m_halt)}, "reset");
    idle_inputs(1);
  endtask

  vec_t tbl[17];

  initial begin
    logic [31:0] exp3;
    logic [15:0] exp1;
    m_halt = 0; m_waited = 0; m_stall = 0; m_flush = 0;
    idle_inputs(0);
    @(posedge CLK); @(posedge CLK); #1;

    //                 name        rst rs urs rt urt exmr exrd mmr mmw br jmp rdy exp
    tbl[0]  = mk("idle",      1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, DEF);
    tbl[1]  = mk("loaduse",   1, 8, 1, 0, 0, 1, 8, 0, 0, 0, 0, 1, LUS);
    tbl[2]  = mk("lu_clear",  1, 8, 1, 0, 0, 0, 8, 0, 0, 0, 0, 1, DEF);
    tbl[3]  = mk("lu_r0",     1, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 1, DEF);
    tbl[4]  = mk("lu_rt",     1, 5, 0, 5, 1, 1, 5, 0, 0, 0, 0, 1, LUS);
    tbl[5]  = mk("lu_nouse",  1, 5, 0, 5, 0, 1, 5, 0, 0, 0, 0, 1, DEF);
    tbl[6]  = mk("br_lu",     1, 8, 1, 0, 0, 1, 8, 0, 0, 1, 0, 1, 9'b111111000);
    tbl[7]  = mk("jmp_lu",    1, 8, 1, 0, 0, 1, 8, 0, 0, 0, 1, 1, LUS);
    tbl[8]  = mk("jmp_held",  1, 8, 1, 0, 0, 0, 8, 0, 0, 0, 1, 1, 9'b111011000);
    tbl[9]  = mk("store_ok",  1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, DEFRQ);
    tbl[10] = mk("miss_br",   1, 8, 1, 0, 0, 1, 8, 1, 0, 1, 1, 0, FRZ);
    tbl[11] = mk("wait2",     1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, FRZ);
    tbl[12] = mk("wait3",     1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, FRZ);
    tbl[13] = mk("release",   1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, DEFRQ);
    tbl[14] = mk("rel_next",  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, DEF);
    tbl[15] = mk("rst_force", 0, 8, 1, 0, 0, 1, 8, 1, 0, 1, 1, 0, DEF);
    tbl[16] = mk("post_rst",  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, DEF);
    for (int i = 0; i < 17; i++) begin
      apply(tbl[i]);
      step(tbl[i].exp, tbl[i].nm);
    end

    // Memory wait of three freeze cycles then release; stall counter must read 3.
    do_reset();
    apply(mk("", 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) step(FRZ, "memwait_frz");
    dmem_ready = 1;
    step(DEFRQ, "memwait_rel");
`ifdef HAZARD_PERF_EN
    exp3 = 32'd3; exp1 = 16'd1;
`else
    exp3 = 32'd0; exp1 = 16'd0;
`endif
    check("stall_eq3", 48'(stall_cycles), 48'(exp3));

    // Branch and load-use together: one flush counted.
    do_reset();
    apply(mk("", 1, 8, 1, 0, 0, 1, 8, 0, 0, 1, 0, 1, 0));
    step(9'b111111000, "br_vs_lu");
    idle_inputs(1);
    check("flush_eq1", 48'(flush_count), 48'(exp1));

    // Timeout: four freeze cycles, then HALT holds for 20 cycles whatever the inputs.
    do_reset();
    apply(mk("", 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    for (int i = 0; i < MT; i++) step(FRZ, "to_frz");
    for (int i = 0; i < 20; i++) begin
      branch_taken = 1'($urandom); jump = 1'($urandom); dmem_ready = 1'($urandom);
      EXE_MemRead = 1; EXE_writeSrc = 3; ID_rs = 3; ID_useRs = 1;
      step(HLT, "halt_hold");
    end
    idle_inputs(0);
    step(9'b110011001, "halt_rst");
    idle_inputs(1);
    step(DEF, "halt_exit");

    // Reset during MEM_WAIT.
    apply(mk("", 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    step(FRZ, "mw_frz1");
    step(FRZ, "mw_frz2");
    Reset = 0;
    step(DEF, "mw_rst");
    idle_inputs(1);
    step(DEF, "mw_exit");

    // Randomized run against the reference model.
    for (int i = 0; i < 600; i++) begin
      Reset        = ($urandom_range(0, 79) != 0);
      ID_rs        = 5'($urandom_range(0, 3));
      ID_rt        = 5'($urandom_range(0, 3));
      EXE_writeSrc = 5'($urandom_range(0, 3));
      ID_useRs     = 1'($urandom);
      ID_useRt     = 1'($urandom);
      EXE_MemRead  = 1'($urandom);
      MEM_MemRead  = ($urandom_range(0, 2) == 0);
      MEM_MemWrite = ($urandom_range(0, 3) == 0);
      branch_taken = ($urandom_range(0, 4) == 0);
      jump         = ($urandom_range(0, 3) == 0);
      dmem_ready   = ($urandom_range(0, 2) != 0);
      step(model_out(), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
